mips_stage_decoder: RTL and testbench
=====================================

// Module: mips_stage_decoder
// PURPOSE
//  Instruction decoder for the 5-stage MIPS pipeline; one copy sits in each of D/E/M/W.
//  Decodes a 32-bit instr into datapath controls, register fields and hazard timing (Tuse/Tnew).
//  Decode is purely combinational; the only state is the MDU start guard.
// PARAMETERS
//  none
// PORTS
//  clk        in   1   clock; only clocks the MDU start-guard flop
//  rst_n      in   1   reset, asynchronous, active-low
//  instr      in   32  instruction held in this stage
//  new_instr  in   1   1 = instr entered this stage at the last clock edge (not stalled, not a bubble)
//  tuse_rs    out  4   stages until rs is needed (0..2); 4'd3 = rs not read
//  tuse_rt    out  4   stages until rt is needed (0..2); 4'd3 = rt not read
//  tnew       out  4   result ready counted from D: 0 none, 1 jal, 2 ALU/mf, 3 load
//  rs, rt     out  5   instr[25:21]/[20:16]; 5'd0 when the field is not read
//  imm16      out  16  instr[15:0]
//  imm26      out  26  instr[25:0]
//  shamt      out  5   instr[10:6]
//  cmpOp      out  4   0 none, 1 beq, 2 bne
//  nPcOp      out  4   0 PC+4, 1 branch, 2 jal (imm26), 3 jr
//  extOp      out  4   0 zero-ext, 1 sign-ext, 2 imm<<16
//  md/mt/mf   out  1   class: mult/multu/div/divu, mthi/mtlo, mfhi/mflo
//  srcASel    out  4   0 rs value; other codes reserved (drive 0)
//  srcBSel    out  4   0 rt value, 1 extended immediate
//  aluOp      out  4   0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sltu, 6 pass-B
//  regDst     out  5   destination GPR: rd (R-type), rt (I-type), 31 (jal), 0 (no write)
//  regWdSel   out  4   0 ALU, 1 memory, 2 PC+8, 3 MDU HI/LO
//  d1Sel/d2Sel out 4   0 register/forwarded data, 1 constant zero (operand not read)
//  mduOp      out  4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
//  mdu_start  out  1   start pulse for a mult/multu/div/divu computation
//  memWrite   out  1   1 for sw/sh/sb
//  memOp      out  4   0 word, 1 half, 2 byte; loads sign-extend
// BEHAVIOUR
//  Supported: add sub and or slt sltu addi andi ori lui lb lh lw sb sh sw beq bne jal jr
//   mult multu div divu mfhi mflo mthi mtlo. nop and any unknown encoding: all controls 0, tnew 0, tuse 3.
//  Tuse: beq/bne rs,rt=0; jr rs=0; ALU/MDU/load/store-address rs=1; R-ALU/md rt=1; store data rt=2.
//  All decode outputs follow instr combinationally; no latency; they are independent of reset.
//  Arithmetic immediates (addi, loads, stores) use extOp=1; andi/ori use 0; lui uses 2 with aluOp 6.
//  mdu_start = md & new_instr (& guard if enabled); it is 0 during reset.
// CONFIGURATION
//  CTRL_START_ONCE_EN defined: flop fired_q (async reset 0); next = mdu_start ? 1 : (new_instr ? fired_q : 0);
//   mdu_start also requires ~fired_q, so new_instr held high across stall cycles fires only once;
//   re-arms after any cycle with new_instr=0. Undefined: no flop, mdu_start = md & new_instr.
// STRUCTURE
//  Shared package: opcode/funct constants and all *Op/*Sel code enums, TUSE_NONE=3.
//  One sub-module natural: tuse_tnew_table (instr class -> tuse_rs/tuse_rt/tnew).
// TESTING
//  addu-style add $3,$1,$2 -> regDst 3, aluOp 0, srcB 0, tnew 2, tuse_rs/rt 1/1.
//  lw $5,-4($6) -> extOp 1, srcB 1, regWdSel 1, memOp 0, tnew 3, rt=0, tuse_rt 3.
//  sh $7,8($1) -> memWrite 1, memOp 1, regDst 0, tuse_rt 2; beq -> cmpOp 1, nPcOp 1, tuse 0/0.
//  jal 0x100 -> nPcOp 2, regDst 31, regWdSel 2, tnew 1; jr $31 -> nPcOp 3, rs 31, tuse_rs 0.
//  mult with new_instr=1 -> mdu_start 1, mduOp 1; new_instr=0 -> 0; with _EN, new_instr high 3 cycles -> 1 pulse.
//  instr=0 or 0xFC000000 -> all controls 0; rst_n=0 mid-mult -> mdu_start 0 immediately.

Source files
------------

// File: rtl/mips_stage_decoder_pkg.sv
// Shared decode constants and control-code enums for the per-stage MIPS decoder.
// Optional feature macro used by the top: CTRL_START_ONCE_EN.
package mips_stage_decoder_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [3:0] TUSE_NONE = 4'd3;

    typedef enum logic [3:0] {
        CLS_NONE, CLS_RALU, CLS_IALU, CLS_LUI,
        CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL,
        CLS_JR, CLS_MD, CLS_MT, CLS_MF
    } instr_cls_e;

    typedef enum logic [3:0] {
        CMP_NONE = 4'd0, CMP_BEQ = 4'd1, CMP_BNE = 4'd2
    } cmp_op_e;

    typedef enum logic [3:0] {
        NPC_PC4 = 4'd0, NPC_BRANCH = 4'd1, NPC_JAL = 4'd2, NPC_JR = 4'd3
    } npc_op_e;

    typedef enum logic [3:0] {
        EXT_ZERO = 4'd0, EXT_SIGN = 4'd1, EXT_LUI = 4'd2
    } ext_op_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
        ALU_SLT = 4'd4, ALU_SLTU = 4'd5, ALU_PASSB = 4'd6
    } alu_op_e;

    typedef enum logic [3:0] {
        SRCB_RT = 4'd0, SRCB_IMM = 4'd1
    } srcb_sel_e;

    typedef enum logic [3:0] {
        WD_ALU = 4'd0, WD_MEM = 4'd1, WD_PC8 = 4'd2, WD_HILO = 4'd3
    } wd_sel_e;

    typedef enum logic [3:0] {
        MDU_NONE = 4'd0, MDU_MULT = 4'd1, MDU_MULTU = 4'd2,
        MDU_DIV = 4'd3, MDU_DIVU = 4'd4, MDU_MFHI = 4'd5,
        MDU_MFLO = 4'd6, MDU_MTHI = 4'd7, MDU_MTLO = 4'd8
    } mdu_op_e;

    typedef enum logic [3:0] {
        MEM_WORD = 4'd0, MEM_HALF = 4'd1, MEM_BYTE = 4'd2
    } mem_op_e;

endpackage

// File: rtl/mips_stage_decoder_tuse_tnew_table.sv
// Hazard timing lookup: instruction class to operand Tuse and result Tnew.
module mips_stage_decoder_tuse_tnew_table
    import mips_stage_decoder_pkg::*;
(
    input  instr_cls_e cls,
    output logic [3:0] tuse_rs,
    output logic [3:0] tuse_rt,
    output logic [3:0] tnew
);

    always_comb begin
        tuse_rs = TUSE_NONE;
        tuse_rt = TUSE_NONE;
        tnew    = 4'd0;
        unique case (cls)
            CLS_RALU: begin
                tuse_rs = 4'd1;
                tuse_rt = 4'd1;
                tnew    = 4'd2;
            end
            CLS_IALU: begin
                tuse_rs = 4'd1;
                tnew    = 4'd2;
            end
            CLS_LUI:  tnew = 4'd2;
            CLS_LOAD: begin
                tuse_rs = 4'd1;
                tnew    = 4'd3;
            end
            CLS_STORE: begin
                tuse_rs = 4'd1;
                tuse_rt = 4'd2;
            end
            CLS_BRANCH: begin
                tuse_rs = 4'd0;
                tuse_rt = 4'd0;
            end
            CLS_JAL:  tnew = 4'd1;
            CLS_JR:   tuse_rs = 4'd0;
            CLS_MD: begin
                tuse_rs = 4'd1;
                tuse_rt = 4'd1;
            end
            CLS_MT:   tuse_rs = 4'd1;
            CLS_MF:   tnew = 4'd2;
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_stage_decoder.sv
// Per-stage MIPS instruction decoder: controls, register fields, Tuse/Tnew.
// Define CTRL_START_ONCE_EN to fire mdu_start only once while new_instr is held.
module mips_stage_decoder
    import mips_stage_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        new_instr,
    output logic [3:0]  tuse_rs,
    output logic [3:0]  tuse_rt,
    output logic [3:0]  tnew,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [15:0] imm16,
    output logic [25:0] imm26,
    output logic [4:0]  shamt,
    output logic [3:0]  cmpOp,
    output logic [3:0]  nPcOp,
    output logic [3:0]  extOp,
    output logic        md,
    output logic        mt,
    output logic        mf,
    output logic [3:0]  srcASel,
    output logic [3:0]  srcBSel,
    output logic [3:0]  aluOp,
    output logic [4:0]  regDst,
    output logic [3:0]  regWdSel,
    output logic [3:0]  d1Sel,
    output logic [3:0]  d2Sel,
    output logic [3:0]  mduOp,
    output logic        mdu_start,
    output logic        memWrite,
    output logic [3:0]  memOp
);

    logic [5:0] op;
    logic [5:0] funct;
    instr_cls_e cls;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign imm16 = instr[15:0];
    assign imm26 = instr[25:0];
    assign shamt = instr[10:6];
    assign srcASel = 4'd0;

    always_comb begin
        cls   = CLS_NONE;
        aluOp = ALU_ADD;
        extOp = EXT_ZERO;
        memOp = MEM_WORD;
        cmpOp = CMP_NONE;
        mduOp = MDU_NONE;
        unique case (op)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADD:   cls = CLS_RALU;
                    FN_SUB:   begin cls = CLS_RALU; aluOp = ALU_SUB;  end
                    FN_AND:   begin cls = CLS_RALU; aluOp = ALU_AND;  end
                    FN_OR:    begin cls = CLS_RALU; aluOp = ALU_OR;   end
                    FN_SLT:   begin cls = CLS_RALU; aluOp = ALU_SLT;  end
                    FN_SLTU:  begin cls = CLS_RALU; aluOp = ALU_SLTU; end
                    FN_JR:    cls = CLS_JR;
                    FN_MULT:  begin cls = CLS_MD; mduOp = MDU_MULT;  end
                    FN_MULTU: begin cls = CLS_MD; mduOp = MDU_MULTU; end
                    FN_DIV:   begin cls = CLS_MD; mduOp = MDU_DIV;   end
                    FN_DIVU:  begin cls = CLS_MD; mduOp = MDU_DIVU;  end
                    FN_MFHI:  begin cls = CLS_MF; mduOp = MDU_MFHI;  end
                    FN_MFLO:  begin cls = CLS_MF; mduOp = MDU_MFLO;  end
                    FN_MTHI:  begin cls = CLS_MT; mduOp = MDU_MTHI;  end
                    FN_MTLO:  begin cls = CLS_MT; mduOp = MDU_MTLO;  end
                    default: ;
                endcase
            end
            OP_ADDI: begin cls = CLS_IALU; extOp = EXT_SIGN; end
            OP_ANDI: begin cls = CLS_IALU; aluOp = ALU_AND; end
            OP_ORI:  begin cls = CLS_IALU; aluOp = ALU_OR;  end
            OP_LUI: begin
                cls   = CLS_LUI;
                aluOp = ALU_PASSB;
                extOp = EXT_LUI;
            end
            OP_LW: begin cls = CLS_LOAD; extOp = EXT_SIGN; end
            OP_LH: begin cls = CLS_LOAD; extOp = EXT_SIGN; memOp = MEM_HALF; end
            OP_LB: begin cls = CLS_LOAD; extOp = EXT_SIGN; memOp = MEM_BYTE; end
            OP_SW: begin cls = CLS_STORE; extOp = EXT_SIGN; end
            OP_SH: begin cls = CLS_STORE; extOp = EXT_SIGN; memOp = MEM_HALF; end
            OP_SB: begin cls = CLS_STORE; extOp = EXT_SIGN; memOp = MEM_BYTE; end
            OP_BEQ: begin cls = CLS_BRANCH; cmpOp = CMP_BEQ; end
            OP_BNE: begin cls = CLS_BRANCH; cmpOp = CMP_BNE; end
            OP_JAL: cls = CLS_JAL;
            default: ;
        endcase
    end

    always_comb begin
        nPcOp    = NPC_PC4;
        regDst   = 5'd0;
        regWdSel = WD_ALU;
        srcBSel  = SRCB_RT;
        memWrite = 1'b0;
        md       = 1'b0;
        mt       = 1'b0;
        mf       = 1'b0;
        unique case (cls)
            CLS_RALU: regDst = instr[15:11];
            CLS_IALU, CLS_LUI: begin
                regDst  = instr[20:16];
                srcBSel = SRCB_IMM;
            end
            CLS_LOAD: begin
                regDst   = instr[20:16];
                srcBSel  = SRCB_IMM;
                regWdSel = WD_MEM;
            end
            CLS_STORE: begin
                srcBSel  = SRCB_IMM;
                memWrite = 1'b1;
            end
            CLS_BRANCH: nPcOp = NPC_BRANCH;
            CLS_JAL: begin
                nPcOp    = NPC_JAL;
                regDst   = 5'd31;
                regWdSel = WD_PC8;
            end
            CLS_JR: nPcOp = NPC_JR;
            CLS_MD: md = 1'b1;
            CLS_MT: mt = 1'b1;
            CLS_MF: begin
                mf       = 1'b1;
                regDst   = instr[15:11];
                regWdSel = WD_HILO;
            end
            default: ;
        endcase
    end

    mips_stage_decoder_tuse_tnew_table u_table (
        .cls     (cls),
        .tuse_rs (tuse_rs),
        .tuse_rt (tuse_rt),
        .tnew    (tnew)
    );

    // Unread operands report register 0 and select the constant-zero path.
    assign rs    = (tuse_rs == TUSE_NONE) ? 5'd0 : instr[25:21];
    assign rt    = (tuse_rt == TUSE_NONE) ? 5'd0 : instr[20:16];
    assign d1Sel = {3'd0, (cls != CLS_NONE) && (tuse_rs == TUSE_NONE)};
    assign d2Sel = {3'd0, (cls != CLS_NONE) && (tuse_rt == TUSE_NONE)};

`ifdef CTRL_START_ONCE_EN
    logic fired_q;
    logic fired_d;

    assign mdu_start = md & new_instr & rst_n & ~fired_q;
    assign fired_d   = mdu_start ? 1'b1 : (new_instr ? fired_q : 1'b0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fired_q <= 1'b0;
        else        fired_q <= fired_d;
    end
`else
    logic unused_clk;
    assign unused_clk = clk;
    assign mdu_start  = md & new_instr & rst_n;
`endif

endmodule

// File: tb/tb_mips_stage_decoder.sv
// Directed scoreboard bench for mips_stage_decoder.
module tb_mips_stage_decoder;

    typedef struct packed {
        logic [3:0] tuse_rs;
        logic [3:0] tuse_rt;
        logic [3:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] regDst;
        logic [3:0] cmpOp;
        logic [3:0] nPcOp;
        logic [3:0] extOp;
        logic [3:0] srcBSel;
        logic [3:0] aluOp;
        logic [3:0] regWdSel;
        logic [3:0] d1Sel;
        logic [3:0] d2Sel;
        logic [3:0] mduOp;
        logic [3:0] memOp;
        logic       md;
        logic       mt;
        logic       mf;
        logic       memWrite;
        logic       mdu_start;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        new_instr;
    logic [3:0]  tuse_rs, tuse_rt, tnew;
    logic [4:0]  rs, rt, shamt, regDst;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [3:0]  cmpOp, nPcOp, extOp, srcASel, srcBSel, aluOp;
    logic [3:0]  regWdSel, d1Sel, d2Sel, mduOp, memOp;
    logic        md, mt, mf, mdu_start, memWrite;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    localparam logic [31:0] I_MULT = 32'h0085_0018;

    always #5 clk = ~clk;

    mips_stage_decoder dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .new_instr(new_instr),
        .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .tnew(tnew),
        .rs(rs), .rt(rt), .imm16(imm16), .imm26(imm26), .shamt(shamt),
        .cmpOp(cmpOp), .nPcOp(nPcOp), .extOp(extOp),
        .md(md), .mt(mt), .mf(mf),
        .srcASel(srcASel), .srcBSel(srcBSel), .aluOp(aluOp),
        .regDst(regDst), .regWdSel(regWdSel),
        .d1Sel(d1Sel), .d2Sel(d2Sel), .mduOp(mduOp),
        .mdu_start(mdu_start), .memWrite(memWrite), .memOp(memOp)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t none();
        exp_t e;
        e = '0;
        e.tuse_rs = 4'd3;
        e.tuse_rt = 4'd3;
        return e;
    endfunction

    function automatic exp_t mult_exp(input logic start);
        exp_t e;
        e = none();
        e.tuse_rs = 4'd1; e.tuse_rt = 4'd1;
        e.rs = 5'd4; e.rt = 5'd5;
        e.md = 1'b1; e.mduOp = 4'd1;
        e.mdu_start = start;
        return e;
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, ".tuse_rs"},   tuse_rs,   e.tuse_rs);
        chk({tag, ".tuse_rt"},   tuse_rt,   e.tuse_rt);
        chk({tag, ".tnew"},      tnew,      e.tnew);
        chk({tag, ".rs"},        rs,        e.rs);
        chk({tag, ".rt"},        rt,        e.rt);
        chk({tag, ".regDst"},    regDst,    e.regDst);
        chk({tag, ".cmpOp"},     cmpOp,     e.cmpOp);
        chk({tag, ".nPcOp"},     nPcOp,     e.nPcOp);
        chk({tag, ".extOp"},     extOp,     e.extOp);
        chk({tag, ".srcASel"},   srcASel,   32'd0);
        chk({tag, ".srcBSel"},   srcBSel,   e.srcBSel);
        chk({tag, ".aluOp"},     aluOp,     e.aluOp);
        chk({tag, ".regWdSel"},  regWdSel,  e.regWdSel);
        chk({tag, ".d1Sel"},     d1Sel,     e.d1Sel);
        chk({tag, ".d2Sel"},     d2Sel,     e.d2Sel);
        chk({tag, ".mduOp"},     mduOp,     e.mduOp);
        chk({tag, ".memOp"},     memOp,     e.memOp);
        chk({tag, ".md"},        md,        e.md);
        chk({tag, ".mt"},        mt,        e.mt);
        chk({tag, ".mf"},        mf,        e.mf);
        chk({tag, ".memWrite"},  memWrite,  e.memWrite);
        chk({tag, ".mdu_start"}, mdu_start, e.mdu_start);
    endtask

    task automatic step(input string tag, input logic [31:0] i,
                        input logic n, input exp_t e);
        instr     = i;
        new_instr = n;
        exp_q.push_back(e);
        #1;
        check_out(tag);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        instr = 32'd0;
        new_instr = 1'b0;
        #2;
        step("mult_in_reset", I_MULT, 1'b1, mult_exp(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        step("mult_after_reset", I_MULT, 1'b1, mult_exp(1'b1));

        @(negedge clk);
        e = none();
        e.tuse_rs = 4'd1; e.tuse_rt = 4'd1; e.tnew = 4'd2;
        e.rs = 5'd1; e.rt = 5'd2; e.regDst = 5'd3;
        step("add", 32'h0022_1820, 1'b0, e);

        @(negedge clk);
        e = none();
        e.tuse_rs = 4'd1; e.tnew = 4'd3; e.rs = 5'd6; e.regDst = 5'd5;
        e.extOp = 4'd1; e.srcBSel = 4'd1; e.regWdSel = 4'd1; e.d2Sel = 4'd1;
        step("lw", 32'h8CC5_FFFC, 1'b0, e);
        chk("lw.imm16", imm16, 32'h0000_FFFC);

        @(negedge clk);
        e = none();
        e.tuse_rs = 4'd1; e.tuse_rt = 4'd2; e.rs = 5'd1; e.rt = 5'd7;
        e.extOp = 4'd1; e.srcBSel = 4'd1; e.memWrite = 1'b1; e.memOp = 4'd1;
        step("sh", 32'hA427_0008, 1'b0, e);

        @(negedge clk);
        e = none();
        e.tuse_rs = 4'd0; e.tuse_rt = 4'd0; e.rs = 5'd1; e.rt = 5'd2;
        e.cmpOp = 4'd1; e.nPcOp = 4'd1;
        step("beq", 32'h1022_0004, 1'b0, e);

        @(negedge clk);
        e = none();
        e.tuse_rs = 4'd0; e.tuse_rt = 4'd0; e.rs = 5'd3; e.rt = 5'd4;
        e.cmpOp = 4'd2; e.nPcOp = 4'd1;
        step("bne", 32'h1464_0002, 1'b0, e);

        @(negedge clk);
        e = none();
        e.tnew = 4'd1; e.nPcOp = 4'd2; e.regDst = 5'd31; e.regWdSel = 4'd2;
        e.d1Sel = 4'd1; e.d2Sel = 4'd1;
        step("jal", 32'h0C00_0100, 1'b0, e);
        chk("jal.imm26", imm26, 32'h0000_0100);

        @(negedge clk);
        e = none();
        e.tuse_rs = 4'd0; e.rs = 5'd31; e.nPcOp = 4'd3; e.d2Sel = 4'd1;
        step("jr", 32'h03E0_0008, 1'b0, e);

        @(negedge clk);
        e = none();
        e.tnew = 4'd2; e.regDst = 5'd4; e.extOp = 4'd2; e.aluOp = 4'd6;
        e.srcBSel = 4'd1; e.d1Sel = 4'd1; e.d2Sel = 4'd1;
        step("lui", 32'h3C04_1234, 1'b0, e);

        @(negedge clk);
        e = none();
        e.tuse_rs = 4'd1; e.tnew = 4'd2; e.rs = 5'd1; e.regDst = 5'd2;
        e.aluOp = 4'd3; e.srcBSel = 4'd1; e.d2Sel = 4'd1;
        step("ori", 32'h3422_00FF, 1'b0, e);

        @(negedge clk);
        e = none();
        e.tuse_rs = 4'd1; e.tuse_rt = 4'd1; e.tnew = 4'd2;
        e.rs = 5'd4; e.rt = 5'd5; e.regDst = 5'd6; e.aluOp = 4'd1;
        step("sub", 32'h0085_3022, 1'b0, e);

        @(negedge clk);
        e = none();
        e.tnew = 4'd2; e.mf = 1'b1; e.mduOp = 4'd5; e.regDst = 5'd9;
        e.regWdSel = 4'd3; e.d1Sel = 4'd1; e.d2Sel = 4'd1;
        step("mfhi", 32'h0000_4810, 1'b1, e);

        @(negedge clk);
        e = none();
        e.tuse_rs = 4'd1; e.rs = 5'd8; e.mt = 1'b1; e.mduOp = 4'd8;
        e.d2Sel = 4'd1;
        step("mtlo", 32'h0100_0013, 1'b0, e);

        @(negedge clk);
        e = none();
        e.tuse_rs = 4'd1; e.tuse_rt = 4'd1; e.rs = 5'd1; e.rt = 5'd2;
        e.md = 1'b1; e.mduOp = 4'd4; e.mdu_start = 1'b1;
        step("divu", 32'h0022_001B, 1'b1, e);

        @(negedge clk);
        step("nop", 32'h0000_0000, 1'b0, none());
        @(negedge clk);
        step("bad_op", 32'hFC00_0000, 1'b1, none());
        @(negedge clk);
        step("sll_unsupported", 32'h0009_4A80, 1'b0, none());
        chk("sll.shamt", shamt, 32'd10);

        @(negedge clk);
        step("mult_no_new", I_MULT, 1'b0, mult_exp(1'b0));
        @(negedge clk);
        step("mult_hold1", I_MULT, 1'b1, mult_exp(1'b1));
`ifdef CTRL_START_ONCE_EN
        @(negedge clk);
        step("mult_hold2", I_MULT, 1'b1, mult_exp(1'b0));
        @(negedge clk);
        step("mult_hold3", I_MULT, 1'b1, mult_exp(1'b0));
`else
        @(negedge clk);
        step("mult_hold2", I_MULT, 1'b1, mult_exp(1'b1));
        @(negedge clk);
        step("mult_hold3", I_MULT, 1'b1, mult_exp(1'b1));
`endif
        @(negedge clk);
        step("mult_bubble", I_MULT, 1'b0, mult_exp(1'b0));
        @(negedge clk);
        step("mult_rearm", I_MULT, 1'b1, mult_exp(1'b1));

        @(negedge clk);
        step("idle", 32'h0000_0000, 1'b0, none());
        @(negedge clk);
        step("mult_pre_rst", I_MULT, 1'b1, mult_exp(1'b1));
        rst_n = 1'b0;
        #1;
        chk("mult_mid_rst.mdu_start", mdu_start, 32'd0);
        chk("mult_mid_rst.md", md, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 32'h0000_0000, 1'b0, none());

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
